// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and its helpers.
//   NOP_INSTR     : filler word presented when no fetched word is available.
//   fetch_state_t : fetch sequencer states.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hE320_F000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,  // nothing pending
        S_RUN  = 2'd1,  // one fetch in flight
        S_HOLD = 2'd2   // stalled, word parked in skid
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding {instr, pc, tag} while downstream stalls.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : capture load_* fields and set valid
//   clear                 : drop the held word (wins over load)
//   load_instr/pc/tag     : word to park
//   valid                 : a word is held
//   held_instr/pc/tag     : the held word
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        load_tag,
    output logic        valid,
    output logic [31:0] held_instr,
    output logic [31:0] held_pc,
    output logic        held_tag
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            held_instr <= '0;
            held_pc    <= '0;
            held_tag   <= 1'b0;
        end else if (clear) begin
            valid      <= 1'b0;
        end else if (load) begin
            valid      <= 1'b1;
            held_instr <= load_instr;
            held_pc    <= load_pc;
            held_tag   <= load_tag;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency synchronous
// instruction memory and presents each word with its branch epoch tag.
// Downstream stalls are absorbed by a one-entry skid register.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   sel_stall      : downstream stall
//   branch_taken   : redirect pulse from execute
//   branch_addr    : redirect byte address (bits [1:0] ignored)
//   imem_addr      : word address to instruction memory (pc[IMEM_AW+1:2])
//   imem_rdata     : memory data for the address captured last edge
//   instr_out      : presented instruction
//   branch_tag     : epoch of instr_out
//   branch_ref     : current epoch
//   instr_pc       : byte address of instr_out
//   valid_out      : instr_out is a real fetched word
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr_out,
    output logic               branch_tag,
    output logic               branch_ref,
    output logic [31:0]        instr_pc,
    output logic               valid_out
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic         epoch, epoch_nx;
    logic         pend_valid, pend_valid_nx;
    logic [31:0]  pend_pc, pend_pc_nx;
    logic         pend_tag, pend_tag_nx;
    logic         issue;
    logic         skid_load, skid_clear;
    logic         skid_valid, skid_tag;
    logic [31:0]  skid_instr, skid_pc;
    logic [31:0]  branch_target;

    // Word-align the redirect target; masking keeps every input bit used.
    assign branch_target = branch_addr & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            epoch      <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            pend_tag   <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            epoch      <= epoch_nx;
            pend_valid <= pend_valid_nx;
            pend_pc    <= pend_pc_nx;
            pend_tag   <= pend_tag_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        epoch_nx      = epoch;
        pend_valid_nx = pend_valid;
        pend_pc_nx    = pend_pc;
        pend_tag_nx   = pend_tag;
        issue         = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        if (branch_taken) begin
            // Redirect overrides stall: flush everything in flight.
            pc_nx         = branch_target;
            epoch_nx      = ~epoch;
            pend_valid_nx = 1'b0;
            skid_clear    = 1'b1;
            state_nx      = S_BOOT;
        end else begin
            unique case (state)
                S_BOOT: begin
                    if (!sel_stall) begin
                        issue    = 1'b1;
                        state_nx = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!sel_stall) begin
                        issue = 1'b1;
                    end else begin
                        // Park the returning word; pc stays so memory keeps
                        // addressing the next sequential word.
                        skid_load     = 1'b1;
                        pend_valid_nx = 1'b0;
                        state_nx      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!sel_stall) begin
                        issue      = 1'b1;
                        skid_clear = 1'b1;
                        state_nx   = S_RUN;
                    end
                end
                default: state_nx = S_BOOT;
            endcase

            if (issue) begin
                pend_pc_nx    = pc;
                pend_tag_nx   = epoch;
                pend_valid_nx = 1'b1;
                pc_nx         = pc + 32'd4;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pend_pc),
        .load_tag   (pend_tag),
        .valid      (skid_valid),
        .held_instr (skid_instr),
        .held_pc    (skid_pc),
        .held_tag   (skid_tag)
    );

    assign imem_addr  = pc[IMEM_AW+1:2];
    assign branch_ref = epoch;

    always_comb begin
        instr_out  = NOP_INSTR;
        instr_pc   = pc;
        branch_tag = epoch;
        valid_out  = 1'b0;
        if (skid_valid) begin
            instr_out  = skid_instr;
            instr_pc   = skid_pc;
            branch_tag = skid_tag;
            valid_out  = 1'b1;
        end else if (pend_valid) begin
            instr_out  = imem_rdata;
            instr_pc   = pend_pc;
            branch_tag = pend_tag;
            valid_out  = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic        branch_tag;
    logic        branch_ref;
    logic [31:0] instr_pc;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel_stall    (sel_stall),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .branch_tag   (branch_tag),
        .branch_ref   (branch_ref),
        .instr_pc     (instr_pc),
        .valid_out    (valid_out)
    );

    always #5 clk = ~clk;

    // Synchronous memory with mem[i] = i.
    always @(posedge clk) imem_rdata <= {22'd0, imem_addr};

    // Reference model: the word currently shown downstream, the next address
    // to fetch, and the epoch.
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_tag;
    logic [31:0] m_next;
    logic        m_epoch;

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = '0;
        m_tag   = 1'b0;
        m_next  = 32'h0000_0000;
        m_epoch = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic br, input logic [31:0] ba);
        if (br) begin
            m_valid = 1'b0;
            m_next  = {ba[31:2], 2'b00};
            m_epoch = ~m_epoch;
        end else if (!st) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_tag   = m_epoch;
            m_next  = m_next + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        logic [31:0] idx;
        idx = m_pc >> 2;
        chk({name, ".valid"}, valid_out, m_valid);
        chk({name, ".instr"}, instr_out, m_valid ? (idx & 32'h3FF) : NOP_INSTR);
        chk({name, ".pc"}, instr_pc, m_valid ? m_pc : m_next);
        chk({name, ".tag"}, branch_tag, m_valid ? m_tag : m_epoch);
        chk({name, ".ref"}, branch_ref, m_epoch);
        chk({name, ".addr"}, imem_addr, (m_next >> 2) & 32'h3FF);
    endtask

    task automatic cycle(input logic st, input logic br, input logic [31:0] ba);
        sel_stall    = st;
        branch_taken = br;
        branch_addr  = ba;
        @(posedge clk);
        #1;
        model_step(st, br, ba);
        branch_taken = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, ".instr"}, instr_out, NOP_INSTR);
        chk({name, ".valid"}, valid_out, 0);
        chk({name, ".pc"}, instr_pc, 32'h0);
        chk({name, ".tag"}, branch_tag, 0);
        chk({name, ".ref"}, branch_ref, 0);
        chk({name, ".addr"}, imem_addr, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] ba;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] epc;
        logic        etag;
        logic        eref;
        logic [9:0]  eaddr;
    } vec_t;

    function automatic vec_t mk(logic st, logic br, logic [31:0] ba, logic ev,
                                logic [31:0] ei, logic [31:0] epc, logic etag,
                                logic eref, logic [9:0] eaddr);
        vec_t v;
        v.st = st; v.br = br; v.ba = ba; v.ev = ev; v.ei = ei;
        v.epc = epc; v.etag = etag; v.eref = eref; v.eaddr = eaddr;
        return v;
    endfunction

    vec_t tbl[19];

    initial begin
        // Directed stream: boot, stall for 3 cycles, redirect, redirect in HOLD.
        tbl[0]  = mk(0, 0, 0,        1, 32'h0,  32'h0,   0, 0, 10'h1);
        tbl[1]  = mk(0, 0, 0,        1, 32'h1,  32'h4,   0, 0, 10'h2);
        tbl[2]  = mk(0, 0, 0,        1, 32'h2,  32'h8,   0, 0, 10'h3);
        tbl[3]  = mk(0, 0, 0,        1, 32'h3,  32'hC,   0, 0, 10'h4);
        tbl[4]  = mk(0, 0, 0,        1, 32'h4,  32'h10,  0, 0, 10'h5);
        tbl[5]  = mk(0, 0, 0,        1, 32'h5,  32'h14,  0, 0, 10'h6);
        tbl[6]  = mk(1, 0, 0,        1, 32'h5,  32'h14,  0, 0, 10'h6);
        tbl[7]  = mk(1, 0, 0,        1, 32'h5,  32'h14,  0, 0, 10'h6);
        tbl[8]  = mk(1, 0, 0,        1, 32'h5,  32'h14,  0, 0, 10'h6);
        tbl[9]  = mk(0, 0, 0,        1, 32'h6,  32'h18,  0, 0, 10'h7);
        tbl[10] = mk(0, 0, 0,        1, 32'h7,  32'h1C,  0, 0, 10'h8);
        tbl[11] = mk(0, 1, 32'h103,  0, NOP_INSTR, 32'h100, 1, 1, 10'h40);
        tbl[12] = mk(0, 0, 0,        1, 32'h40, 32'h100, 1, 1, 10'h41);
        tbl[13] = mk(0, 0, 0,        1, 32'h41, 32'h104, 1, 1, 10'h42);
        tbl[14] = mk(1, 0, 0,        1, 32'h41, 32'h104, 1, 1, 10'h42);
        tbl[15] = mk(1, 1, 32'h200,  0, NOP_INSTR, 32'h200, 0, 0, 10'h80);
        tbl[16] = mk(1, 0, 0,        0, NOP_INSTR, 32'h200, 0, 0, 10'h80);
        tbl[17] = mk(0, 0, 0,        1, 32'h80, 32'h200, 0, 0, 10'h81);
        tbl[18] = mk(0, 0, 0,        1, 32'h81, 32'h204, 0, 0, 10'h82);

        // Reset state, and a redirect during reset is ignored.
        #1;
        check_reset_outputs("reset");
        branch_taken = 1'b1;
        branch_addr  = 32'h500;
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        check_reset_outputs("branch_in_reset");
        release_reset();

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].st, tbl[i].br, tbl[i].ba);
            chk($sformatf("tbl%0d.valid", i), valid_out, tbl[i].ev);
            chk($sformatf("tbl%0d.instr", i), instr_out, tbl[i].ei);
            chk($sformatf("tbl%0d.pc", i), instr_pc, tbl[i].epc);
            chk($sformatf("tbl%0d.tag", i), branch_tag, tbl[i].etag);
            chk($sformatf("tbl%0d.ref", i), branch_ref, tbl[i].eref);
            chk($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].eaddr);
        end

        // Asynchronous reset while a word sits in the skid register.
        cycle(1, 0, 0);
        chk("pre_rst_hold.valid", valid_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst_mid_stall");
        release_reset();

        // Redirect while word 4 is presented: word 4 keeps tag 0.
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        chk("w4.pc", instr_pc, 32'h10);
        chk("w4.tag", branch_tag, 0);
        chk("w4.ref", branch_ref, 0);
        cycle(0, 1, 32'h103);
        chk("redir.ref", branch_ref, 1);
        chk("redir.valid", valid_out, 0);
        cycle(0, 0, 0);
        chk("redir_tgt.pc", instr_pc, 32'h100);
        chk("redir_tgt.tag", branch_tag, 1);
        chk("redir_tgt.valid", valid_out, 1);

        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        chk("wrap_last.pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_last.addr", imem_addr, 10'h0);
        cycle(0, 0, 0);
        chk("wrap_first.pc", instr_pc, 32'h0);
        chk("wrap_first.instr", instr_out, 32'h0);
        check_model("wrap");

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic        st, br;
            logic [31:0] ba;
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                check_reset_outputs("rand_async_rst");
                release_reset();
            end
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 15) == 0);
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cycle(st, br, ba);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of `pipeline_unit`. It owns the PC and drives the synchronous instruction memory, which has 1-cycle read latency. Each returned word is presented as `instr_in` together with a 1-bit branch epoch tag (`branch_in`) and the current epoch (`branch_ref`), so `pipeline_unit` squashes wrong-path words to NOP. Downstream stalls are absorbed by a one-entry skid register, so no fetched word is lost or duplicated.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `IMEM_AW`, 10: instruction-memory word-address width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sel_stall`  in  1  downstream stall; same signal `pipeline_unit` receives.
- `branch_taken`  in  1  redirect request from execute; single-cycle pulse.
- `branch_addr`  in  32  redirect target, byte address; bits [1:0] ignored.
- `imem_addr`  out  IMEM_AW  word address to instruction memory; equals `pc[IMEM_AW+1:2]`, combinational from the `pc` register.
- `imem_rdata`  in  32  memory data for the address captured at the previous edge.
- `instr_out`  out  32  to `pipeline_unit.instr_in`.
- `branch_tag`  out  1  epoch of `instr_out`; to `branch_in`.
- `branch_ref`  out  1  current epoch register; to `pipeline_unit.branch_ref`.
- `instr_pc`  out  32  byte address of `instr_out`.
- `valid_out`  out  1  `instr_out` is a real fetched word.

## Operation
- Registers: `pc`, `epoch`, `pend_valid/pend_pc/pend_tag` (fetch in flight), `skid_valid/skid_instr/skid_pc/skid_tag`, and 2-bit state.
- States:
  - S_BOOT: nothing pending.
  - S_RUN: one fetch pending.
  - S_HOLD: stalled, word parked in skid.
- Output source priority:
  - `skid_valid` selects the skid fields.
  - Otherwise `pend_valid` selects `imem_rdata`, `pend_pc` and `pend_tag`.
  - Otherwise the output is NOP 32'hE320F000, `instr_pc` = `pc`, `branch_tag` = `epoch`, `valid_out` = 0.
- "Issue" at an edge means: `pend_pc<=pc`, `pend_tag<=epoch`, `pend_valid<=1`, `pc<=pc+4` (wraps modulo 2^32).
- Transitions, evaluated at each rising edge:
  - `branch_taken` (highest priority, any state, overrides stall): `pc<={branch_addr[31:2],2'b00}`, `epoch<=~epoch`, `pend_valid<=0`, `skid_valid<=0`, go to S_BOOT.
  - S_BOOT, !stall: issue; go to S_RUN. S_BOOT, stall: hold all registers.
  - S_RUN, !stall: issue; stay in S_RUN.
  - S_RUN, stall: skid captures `imem_rdata/pend_pc/pend_tag`, `skid_valid<=1`, `pend_valid<=0`, `pc` held; go to S_HOLD.
  - S_HOLD, stall: hold all registers.
  - S_HOLD, !stall: skid word is consumed at this edge; issue; `skid_valid<=0`; go to S_RUN.
- Wrong-path words keep their old tag. After a redirect `branch_ref` is already toggled, so `pipeline_unit` sees a tag mismatch and substitutes NOP.

## Timing
- Reset (asynchronous): `pc=RESET_PC`, `epoch=0`, state S_BOOT, all valid flags 0.
- Outputs during reset: `instr_out`=NOP, `branch_tag`=0, `branch_ref`=0, `valid_out`=0, `instr_pc`=RESET_PC.
- Latency: word at address A is on `instr_out` in the cycle after the edge that issued A. After reset, the first valid word appears after the 1st edge.
- Steady state: one word per cycle.
- Redirect to word valid: 2 edges.
- Stall to resume: no bubble. The skid word is presented in the release cycle, and the next sequential word follows one cycle later.
- `branch_taken` during reset is ignored.
- Reset mid-stall or mid-redirect discards skid and pending state.

## Structure
- Shared `cpu_pkg`: `NOP_INSTR` (32'hE320F000), `fetch_state_t` enum {S_BOOT, S_RUN, S_HOLD}.
- Optional sub-module `fetch_skid_buf`: one-entry {instr, pc, tag} register with load/clear/valid.
- The remainder stays in `fetch_unit`.

## Test plan
- Reset, `RESET_PC`=0 → NOP, `valid_out`=0, `imem_addr`=0. After 3 edges, memory with mem[i]=i → `instr_out`=2, `instr_pc`=8, `branch_tag`=0.
- Streaming with no stall → `instr_pc` increments by 4 every cycle; no gaps and no repeats.
- Stall in S_RUN while presenting word 5 for 3 cycles → `instr_out` stays 5 and `imem_addr` stays 6 throughout. After release: 5, then 6, 7.
- `branch_taken` with `branch_addr`=32'h103 while word 4 is pending → `branch_ref` 0→1. Word 4 keeps tag 0 and is squashed downstream. Next valid word has `instr_pc`=32'h100 and tag 1.
- `branch_taken` together with `sel_stall` in S_HOLD → skid flushed, redirect taken, S_BOOT held until stall drops. Then the target word follows one cycle later.
- `pc`=32'hFFFF_FFFC, no stall → next issue wraps to address 0; `rst_n` asserted mid-stall → NOP and `valid_out`=0 immediately, without waiting for a clock edge.
